// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES decryption constants, state types and GF(2^8) helpers
//
// Contents:
//   GF_POLY              AES field reduction polynomial x^8+x^4+x^3+x+1
//   IMC_C0..IMC_C3       InvMixColumns row-0 coefficients {0e,0b,0d,09};
//                        the other rows are right rotations of this row
//   state_t              128-bit AES state, byte 0 at [127:120], column-major
//   column_t             one 32-bit state column, row 0 at [31:24]
//   xtime()              multiply by x (0x02) in GF(2^8)
//   gf_mul()             general GF(2^8) multiply, shift-and-add form

package aes_pkg;

    localparam logic [8:0] GF_POLY = 9'h11B;

    localparam logic [7:0] IMC_C0 = 8'h0e;
    localparam logic [7:0] IMC_C1 = 8'h0b;
    localparam logic [7:0] IMC_C2 = 8'h0d;
    localparam logic [7:0] IMC_C3 = 8'h09;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  column_t;

    // The x^8 term of the polynomial is implied by the bit shifted out, so
    // only the low eight bits are folded back in.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY[7:0] : 8'h00);
    endfunction

    // With a constant coefficient, synthesis reduces this to a small XOR tree.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                acc = acc ^ p;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/inv_mix_column.sv
// rtl/inv_mix_column.sv - combinational InvMixColumns transform of one 32-bit column
//
// Ports:
//   col_in   input  32  column bytes a0..a3, a0 at [31:24]
//   col_out  output 32  transformed column b0..b3, b0 at [31:24]
//
// b_r = sum over k of M[r][k] * a_k, with M row 0 = {0e,0b,0d,09} and each
// following row rotated right by one position.

module inv_mix_column
    import aes_pkg::*;
(
    input  column_t col_in,
    output column_t col_out
);

    logic [7:0] a0;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul(a0, IMC_C0) ^ gf_mul(a1, IMC_C1)
                          ^ gf_mul(a2, IMC_C2) ^ gf_mul(a3, IMC_C3);
    assign col_out[23:16] = gf_mul(a0, IMC_C3) ^ gf_mul(a1, IMC_C0)
                          ^ gf_mul(a2, IMC_C1) ^ gf_mul(a3, IMC_C2);
    assign col_out[15:8]  = gf_mul(a0, IMC_C2) ^ gf_mul(a1, IMC_C3)
                          ^ gf_mul(a2, IMC_C0) ^ gf_mul(a3, IMC_C1);
    assign col_out[7:0]   = gf_mul(a0, IMC_C1) ^ gf_mul(a1, IMC_C2)
                          ^ gf_mul(a2, IMC_C3) ^ gf_mul(a3, IMC_C0);

endmodule

// File: rtl/inv_round_key_mix.sv
// rtl/inv_round_key_mix.sv - AES decryption AddRoundKey + InvMixColumns, two-stage pipeline
//
// Parameters:
//   ROUND_W     width of the round tag carried with each state
// Ports:
//   clk         input   1        rising-edge clock
//   reset_n     input   1        asynchronous active-low reset
//   in_valid    input   1        input state valid
//   in_ready    output  1        block accepts input this cycle
//   in_data     input   128      state after InvSubBytes, byte 0 at [127:120]
//   in_key      input   128      round key, same byte order
//   in_no_mix   input   1        skip InvMixColumns (final round)
//   in_round    input   ROUND_W  round tag, passed through
//   out_valid   output  1        result valid
//   out_ready   input   1        downstream accepts result
//   out_data    output  128      result state
//   out_round   output  ROUND_W  tag of out_data
//
// Build option:
//   INV_ROUND_KEY_MIX_SKID_EN  adds a one-entry skid buffer in front of S1 so
//                              in_ready comes straight from a flop and has no
//                              combinational path from out_ready.
//
// S1 holds in_data ^ in_key plus its no_mix flag and tag; S2 holds the
// InvMixColumns result (or the S1 state untouched for the final round).

module inv_round_key_mix
    import aes_pkg::*;
#(
    parameter int ROUND_W = 4
)
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [127:0]       in_key,
    input  logic               in_no_mix,
    input  logic [ROUND_W-1:0] in_round,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic [ROUND_W-1:0] out_round
);

    logic               in_fire;

    // Whatever is presented to S1 this cycle: the input port, or the skid
    // entry when one is parked.
    logic               src_valid;
    state_t             src_data;
    logic               src_no_mix;
    logic [ROUND_W-1:0] src_round;

    logic               s1_valid;
    state_t             s1_data;
    logic               s1_no_mix;
    logic [ROUND_W-1:0] s1_round;

    logic               s2_valid;
    state_t             s2_data;
    logic [ROUND_W-1:0] s2_round;

    logic               s1_take;
    logic               s2_take;
    state_t             mix_data;
    state_t             s2_next_data;

    // A stage may load when it is empty or its occupant leaves this cycle.
    assign s2_take = !s2_valid || out_ready;
    assign s1_take = !s1_valid || s2_take;
    assign in_fire = in_valid && in_ready;

`ifdef INV_ROUND_KEY_MIX_SKID_EN
    logic               skid_valid;
    state_t             skid_data;
    logic               skid_no_mix;
    logic [ROUND_W-1:0] skid_round;

    // skid_valid is a flop, so in_ready never depends on out_ready. reset_n
    // gating only forces ready low while reset is held.
    assign in_ready   = reset_n && !skid_valid;

    assign src_valid  = skid_valid || in_fire;
    assign src_data   = skid_valid ? skid_data   : (in_data ^ in_key);
    assign src_no_mix = skid_valid ? skid_no_mix : in_no_mix;
    assign src_round  = skid_valid ? skid_round  : in_round;

    // An accepted input parks here only when S1 cannot take it; the parked
    // entry has priority into S1, and in_ready stays low until it drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_no_mix <= 1'b0;
            skid_round  <= '0;
        end else if (skid_valid) begin
            if (s1_take) begin
                skid_valid <= 1'b0;
            end
        end else if (in_fire && !s1_take) begin
            skid_valid  <= 1'b1;
            skid_data   <= in_data ^ in_key;
            skid_no_mix <= in_no_mix;
            skid_round  <= in_round;
        end
    end
`else
    assign in_ready   = reset_n && s1_take;

    assign src_valid  = in_fire;
    assign src_data   = in_data ^ in_key;
    assign src_no_mix = in_no_mix;
    assign src_round  = in_round;
`endif

    // Stage 1: AddRoundKey result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            s1_no_mix <= 1'b0;
            s1_round  <= '0;
        end else if (s1_take) begin
            s1_valid <= src_valid;
            if (src_valid) begin
                s1_data   <= src_data;
                s1_no_mix <= src_no_mix;
                s1_round  <= src_round;
            end
        end
    end

    // Four column transforms over the S1 state, column 0 at the top bits.
    for (genvar c = 0; c < 4; c++) begin : g_col
        inv_mix_column u_inv_mix_column (
            .col_in  (s1_data[127-32*c -: 32]),
            .col_out (mix_data[127-32*c -: 32])
        );
    end

    assign s2_next_data = s1_no_mix ? s1_data : mix_data;

    // Stage 2: output register. Holds while out_valid && !out_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_round <= '0;
        end else if (s2_take) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data  <= s2_next_data;
                s2_round <= s1_round;
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_round = s2_round;

endmodule

// File: doc/inv_round_key_mix.md
INV_ROUND_KEY_MIX -- requirements
Module: inv_round_key_mix

Interface
REQ-001 SHALL have parameter ROUND_W, default 4, width of the round tag carried alongside the data.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream inverse-SubBytes state valid.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_data  input  128  state, byte 0 at [127:120], column-major.
REQ-007 SHALL have port in_key  input  128  round key, same byte order.
REQ-008 SHALL have port in_no_mix  input  1  skip InvMixColumns (final decryption round).
REQ-009 SHALL have port in_round  input  ROUND_W  round tag, passed through unchanged.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result.
REQ-012 SHALL have port out_data  output  128  result state.
REQ-013 SHALL have port out_round  output  ROUND_W  tag of out_data.

Function
REQ-014 SHALL transfer on a port only in a cycle where valid and ready are both 1.
REQ-015 SHALL use a two-stage pipeline: S1 registers in_data XOR in_key with no_mix and round; S2 registers InvMixColumns(S1 data), or S1 data unchanged when no_mix=1.
REQ-016 SHALL give latency of exactly 2 cycles from input transfer to out_valid with out_ready held 1.
REQ-017 SHALL sustain one transfer per cycle when out_ready=1 continuously.
REQ-018 SHALL apply InvMixColumns per 32-bit column with coefficient matrix rows {0e,0b,0d,09} rotated, GF(2^8) reduction polynomial 0x11B.
REQ-019 SHALL advance each stage when it is empty or its content moves on the same cycle (bubble collapse); otherwise hold.
REQ-020 SHALL keep out_data, out_round, out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL, when both stages are full and out_ready=0, drive in_ready=0 and accept no data.
REQ-022 SHALL, on simultaneous output transfer and input transfer with a full pipe, shift without loss or duplication.
REQ-023 SHALL preserve order; out_round of each result equals its in_round.
REQ-024 SHALL ignore in_data, in_key, in_no_mix, in_round when in_valid=0.

Reset
REQ-025 SHALL, on reset_n low, asynchronously clear both stage valids, out_valid=0, out_data=0, out_round=0.
REQ-026 SHALL discard any in-flight data on reset mid-operation; no output after release until a new input transfer.
REQ-027 SHALL drive in_ready=0 while reset_n is low and 1 in the first cycle after release.

Configuration
REQ-028 SHALL, with macro INV_ROUND_KEY_MIX_SKID_EN defined, insert a 1-entry skid buffer so in_ready is a registered signal with no combinational path from out_ready.
REQ-029 SHALL, without INV_ROUND_KEY_MIX_SKID_EN, drive in_ready combinationally as NOT(S1 full) OR S1 advancing.
REQ-030 SHALL keep latency, throughput and data results identical in both configurations.

Structure
REQ-031 SHALL place the 0x11B reduction constant, the InvMixColumns coefficients (0x0e, 0x0b, 0x0d, 0x09) and a 128-bit state type in shared package aes_pkg.
REQ-032 SHALL instantiate sub-module inv_mix_column (32-bit combinational column transform) four times.

Verification
REQ-033 SHALL cover: in_data=8e4da1bc x4 columns, key=0, no_mix=0 -> out_data=db135345 x4 columns, 2 cycles later.
REQ-034 SHALL cover: in_data=01010101 x4 columns, key=0, no_mix=0 -> out_data=01010101 x4 columns.
REQ-035 SHALL cover: in_data=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f, no_mix=1 -> out_data=00102030405060708090a0b0c0d0e0f0.
REQ-036 SHALL cover: 3 back-to-back inputs, round 9, 8, 7, with out_ready=0 for 4 cycles -> in_ready=0 with 2 held, then outputs 9, 8, 7 in order, no loss or duplication.
REQ-037 SHALL cover: reset_n pulsed low with 2 items in flight -> out_valid=0 immediately, no output until a new input.
REQ-038 SHALL cover: random valid/ready toggling over 1000 items, both macro settings -> all outputs match the reference model in order.
